// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite type definitions for the slave front end.
//   htrans_t       : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_t        : response encoding (OKAY/ERROR)
//   hsize_t        : transfer size encoding
//   ahb_dp_state_t : data-phase state of the memory front end; the ERR1/ERR2
//                    states exist only when AHBMEM_ERR_EN is defined
//   max_hsize()    : largest legal HSIZE for a given memory word width
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4WORD = 3'b100,
    HSIZE_8WORD = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_t;

`ifdef AHBMEM_ERR_EN
  typedef enum logic [2:0] {
    DP_IDLE  = 3'd0,
    DP_WRITE = 3'd1,
    DP_READ  = 3'd2,
    DP_ERR1  = 3'd3,
    DP_ERR2  = 3'd4
  } ahb_dp_state_t;
`else
  typedef enum logic [2:0] {
    DP_IDLE  = 3'd0,
    DP_WRITE = 3'd1,
    DP_READ  = 3'd2
  } ahb_dp_state_t;
`endif

  // log2(data_width/8): the widest transfer the memory word can hold.
  function automatic logic [2:0] max_hsize(input int data_width);
    case (data_width)
      16:      return 3'd1;
      32:      return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mem_if.sv
// ----------------------------------------------------------------------------
// ahb_mem_if
// AHB-Lite slave front end for a synchronous memory with combinational read.
// Address phases are captured at the accepting edge; the following cycle is
// the data phase in which rdEn/wrEn/Addr/Datai drive the memory. Zero wait
// states. Optional macro AHBMEM_ERR_EN adds a two-cycle ERROR response for
// accesses outside the window or wider than the memory word.
// Ports:
//   clk, HRESET (async, active high)
//   AHB side : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA (in)
//              HRDATA, HREADYOUT, HRESP (out)
//   Memory   : rdEn, wrEn, Addr, Datai (out), Datao (in)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_mem_if
  import ahb_pkg::*;
#(
  parameter int SLAVE_ADDRWIDTH = 8,
  parameter int SLAVE_DATAWIDTH = 8,
  parameter int HADDRWIDTH      = 32,
  parameter int HDATAWIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [HADDRWIDTH-1:0]      HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic                       HREADY,
  input  logic [HDATAWIDTH-1:0]      HWDATA,
  output logic [HDATAWIDTH-1:0]      HRDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic                       rdEn,
  output logic                       wrEn,
  output logic [SLAVE_ADDRWIDTH-1:0] Addr,
  output logic [SLAVE_DATAWIDTH-1:0] Datai,
  input  logic [SLAVE_DATAWIDTH-1:0] Datao
);

  ahb_dp_state_t              state_q, state_d;
  logic [SLAVE_ADDRWIDTH-1:0] addr_q, addr_d;
  logic                       accept;

  // Bits of the bus that the memory front end never looks at (upper data
  // lanes, SEQ/NONSEQ distinction, and address/size when checking is off).
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HWDATA, HADDR, HSIZE};

`ifdef AHBMEM_ERR_EN
  logic illegal;
  assign illegal = (|HADDR[HADDRWIDTH-1:SLAVE_ADDRWIDTH])
                 | (HSIZE > max_hsize(SLAVE_DATAWIDTH));
  // The first ERROR cycle holds HREADYOUT low, so no address phase can be
  // taken there even if HREADY is seen high.
  assign accept = HSEL & HREADY & HTRANS[1] & (state_q != DP_ERR1);
`else
  assign accept = HSEL & HREADY & HTRANS[1];
`endif

  always_comb begin
    state_d = DP_IDLE;
    addr_d  = addr_q;
    if (accept) begin
      addr_d  = HADDR[SLAVE_ADDRWIDTH-1:0];
      state_d = HWRITE ? DP_WRITE : DP_READ;
`ifdef AHBMEM_ERR_EN
      if (illegal) begin
        state_d = DP_ERR1;
      end
`endif
    end
`ifdef AHBMEM_ERR_EN
    if (state_q == DP_ERR1) begin
      state_d = DP_ERR2;
    end
`endif
  end

  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      state_q <= DP_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = OKAY;
    rdEn      = (state_q == DP_READ);
    wrEn      = (state_q == DP_WRITE);
    Addr      = addr_q;
    HRDATA    = '0;
    Datai     = '0;
    if (state_q == DP_READ) begin
      HRDATA[SLAVE_DATAWIDTH-1:0] = Datao;
    end
    if (state_q == DP_WRITE) begin
      Datai = HWDATA[SLAVE_DATAWIDTH-1:0];
    end
`ifdef AHBMEM_ERR_EN
    if (state_q == DP_ERR1) begin
      HREADYOUT = 1'b0;
      HRESP     = ERROR;
    end
    if (state_q == DP_ERR2) begin
      HRESP = ERROR;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_if.sv
// ----------------------------------------------------------------------------
// tb_ahb_mem_if
// Self-checking bench for ahb_mem_if with a behavioural memory attached and a
// transaction-level reference model (pending transfer + shadow memory).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ahb_mem_if;
  import ahb_pkg::*;

`ifdef AHBMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  wire  [31:0] HRDATA;
  wire         HREADYOUT, HRESP, rdEn, wrEn;
  wire  [7:0]  Addr, Datai, Datao;

  always #5 clk = ~clk;

  ahb_mem_if #(
    .SLAVE_ADDRWIDTH(8), .SLAVE_DATAWIDTH(8), .HADDRWIDTH(32), .HDATAWIDTH(32)
  ) dut (
    .clk(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .rdEn(rdEn),
    .wrEn(wrEn), .Addr(Addr), .Datai(Datai), .Datao(Datao)
  );

  // Behavioural synchronous-write, combinational-read memory.
  logic [7:0] mem [0:255];
  always @(posedge clk) if (wrEn) mem[Addr] <= Datai;
  assign Datao = rdEn ? mem[Addr] : 8'hzz;

  int checks = 0;
  int errors = 0;

  // Reference model: what data phase is pending, plus a shadow memory.
  typedef enum int {K_NONE, K_RD, K_WR, K_E1, K_E2} kind_e;
  kind_e      pend_kind;
  logic [7:0] pend_addr, last_addr;
  logic [7:0] ref_mem [0:255];

  logic [31:0] exp_hrdata;
  logic [7:0]  exp_addr, exp_datai;
  logic        exp_rden, exp_wren, exp_hreadyout, exp_hresp;

  task automatic model_reset();
    pend_kind = K_NONE;
    pend_addr = 8'h00;
    last_addr = 8'h00;
  endtask

  // One bus cycle: present an address phase (and HWDATA for the current data
  // phase), then at mid-cycle derive expectations for the data phase in
  // progress and advance the model.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic rdy, input logic [31:0] wdata);
    logic acc;
    @(posedge clk); #1;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr;
    HSIZE = size; HREADY = rdy; HWDATA = wdata;
    @(negedge clk);
    exp_rden      = (pend_kind == K_RD);
    exp_wren      = (pend_kind == K_WR);
    exp_hrdata    = (pend_kind == K_RD) ? {24'h0, ref_mem[pend_addr]} : 32'h0;
    exp_datai     = (pend_kind == K_WR) ? wdata[7:0] : 8'h00;
    exp_hreadyout = (pend_kind != K_E1);
    exp_hresp     = (pend_kind == K_E1) || (pend_kind == K_E2);
    exp_addr      = last_addr;
    if (pend_kind == K_WR) ref_mem[pend_addr] = wdata[7:0];
    acc = sel && rdy && trans[1] && (pend_kind != K_E1);
    if (pend_kind == K_E1) begin
      pend_kind = K_E2;
    end else if (acc) begin
      last_addr = addr[7:0];
      pend_addr = addr[7:0];
      if (ERR_EN && ((addr[31:8] != 24'h0) || (size > 3'd0))) pend_kind = K_E1;
      else pend_kind = wr ? K_WR : K_RD;
    end else begin
      pend_kind = K_NONE;
    end
  endtask

  task automatic idle_step(input logic [31:0] wdata);
    step(1'b0, IDLE, 1'b0, 32'h0, 3'd0, 1'b1, wdata);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HSEL = 0; HTRANS = IDLE; HWRITE = 0; HADDR = 0;
    HSIZE = 0; HREADY = 1; HWDATA = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({HRDATA, HREADYOUT, HRESP, rdEn, wrEn, Addr, Datai} !==
        {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got %h/%b/%b/%b/%b/%h/%h", HRDATA, HREADYOUT,
               HRESP, rdEn, wrEn, Addr, Datai);
    end
    HRESET = 1'b0;

    // Reset in the middle of a write data phase.
    step(1'b1, NONSEQ, 1'b1, 32'h10, 3'd0, 1'b1, 32'h0);
    @(posedge clk); #1;
    HSEL = 0; HTRANS = IDLE; HWDATA = 32'hA5;
    @(negedge clk);
    checks++;
    if (wrEn !== 1'b1 || Datai !== 8'hA5 || Addr !== 8'h10) begin
      errors++;
      $display("FAIL pre_reset_write: wrEn=%b Datai=%h Addr=%h want 1/a5/10",
               wrEn, Datai, Addr);
    end
    HRESET = 1'b1; #1;
    checks++;
    if ({HRDATA, HREADYOUT, HRESP, rdEn, wrEn, Addr, Datai} !==
        {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_values: got %h/%b/%b/%b/%b/%h/%h", HRDATA,
               HREADYOUT, HRESP, rdEn, wrEn, Addr, Datai);
    end
    @(posedge clk); @(negedge clk);
    HRESET = 1'b0;
    model_reset();
    step(1'b1, NONSEQ, 1'b0, 32'h10, 3'd0, 1'b1, 32'h0);
    idle_step(32'h0);
    checks++;
    if (rdEn !== 1'b1 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_dropped_write: rdEn=%b HRDATA=%h want 1/00000000",
               rdEn, HRDATA);
    end
  endtask

  task automatic test_write_read();
    step(1'b1, NONSEQ, 1'b1, 32'h20, 3'd0, 1'b1, 32'h0);
    step(1'b1, NONSEQ, 1'b0, 32'h20, 3'd0, 1'b1, 32'hFFFF_FF3C);
    checks++;
    if ({wrEn, rdEn, Datai, Addr, HREADYOUT} !== {1'b1, 1'b0, 8'h3C, 8'h20, 1'b1}) begin
      errors++;
      $display("FAIL wr_phase: wrEn=%b rdEn=%b Datai=%h Addr=%h rdy=%b want 1/0/3c/20/1",
               wrEn, rdEn, Datai, Addr, HREADYOUT);
    end
    idle_step(32'h0);
    checks++;
    if ({wrEn, rdEn, HRDATA, HREADYOUT} !== {1'b0, 1'b1, 32'h3C, 1'b1}) begin
      errors++;
      $display("FAIL rd_phase: wrEn=%b rdEn=%b HRDATA=%h rdy=%b want 0/1/0000003c/1",
               wrEn, rdEn, HRDATA, HREADYOUT);
    end
    idle_step(32'h0);
    checks++;
    if ({rdEn, wrEn, HRDATA} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL after_rd: rdEn=%b wrEn=%b HRDATA=%h want 0/0/0", rdEn, wrEn, HRDATA);
    end
  endtask

  task automatic test_idle_busy_desel();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       step(1'b1, IDLE,   1'b1, 32'h30, 3'd0, 1'b1, 32'h0);
        1:       step(1'b1, BUSY,   1'b0, 32'h31, 3'd0, 1'b1, 32'h0);
        default: step(1'b0, NONSEQ, 1'b1, 32'h32, 3'd0, 1'b1, 32'h0);
      endcase
      idle_step(32'hFF);
      checks++;
      if ({rdEn, wrEn, HRESP, HREADYOUT} !== 4'b0001) begin
        errors++;
        $display("FAIL no_xfer_%0d: rdEn=%b wrEn=%b HRESP=%b rdy=%b want 0/0/0/1",
                 i, rdEn, wrEn, HRESP, HREADYOUT);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, NONSEQ, i[0], 32'h44, 3'd0, 1'b0, 32'h0);
      else       idle_step(32'h0);
      checks++;
      if ({rdEn, wrEn, HRESP} !== 3'b000 || Addr !== exp_addr) begin
        errors++;
        $display("FAIL stall_%0d: rdEn=%b wrEn=%b HRESP=%b Addr=%h want 0/0/0/%h",
                 i, rdEn, wrEn, HRESP, Addr, exp_addr);
      end
    end
  endtask

`ifdef AHBMEM_ERR_EN
  task automatic test_errors();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) step(1'b1, NONSEQ, 1'b1, 32'h100, 3'd0, 1'b1, 32'h0);
      else        step(1'b1, NONSEQ, 1'b0, 32'h004, 3'b010, 1'b1, 32'h0);
      step(1'b0, IDLE, 1'b0, 32'h0, 3'd0, 1'b0, 32'h99);
      checks++;
      if ({HREADYOUT, HRESP, rdEn, wrEn} !== 4'b0100) begin
        errors++;
        $display("FAIL err1_%0d: rdy=%b HRESP=%b rdEn=%b wrEn=%b want 0/1/0/0",
                 i, HREADYOUT, HRESP, rdEn, wrEn);
      end
      idle_step(32'h99);
      checks++;
      if ({HREADYOUT, HRESP, rdEn, wrEn} !== 4'b1100) begin
        errors++;
        $display("FAIL err2_%0d: rdy=%b HRESP=%b rdEn=%b wrEn=%b want 1/1/0/0",
                 i, HREADYOUT, HRESP, rdEn, wrEn);
      end
    end
    step(1'b1, NONSEQ, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    idle_step(32'h0);
    checks++;
    if (HRDATA !== 32'h0 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write: HRDATA=%h HRESP=%b want 0/0", HRDATA, HRESP);
    end
  endtask
`else
  task automatic test_alias();
    step(1'b1, NONSEQ, 1'b1, 32'h0000_0105, 3'd0, 1'b1, 32'h0);
    step(1'b1, NONSEQ, 1'b0, 32'h0000_0005, 3'd0, 1'b1, 32'h77);
    idle_step(32'h0);
    checks++;
    if (HRDATA !== 32'h77 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL alias: HRDATA=%h HRESP=%b want 00000077/0", HRDATA, HRESP);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < 400; i++) begin
      if (ERR_EN) begin
        a  = {24'h0, 8'($urandom_range(0, 15))};
        sz = 3'd0;
      end else begin
        a  = {($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'h0,
              8'($urandom_range(0, 15))};
        sz = 3'($urandom);
      end
      step(1'($urandom), 2'($urandom), 1'($urandom), a, sz,
           ($urandom_range(0, 3) != 0), $urandom);
      checks++;
      if ({HRDATA, HREADYOUT, HRESP, rdEn, wrEn, Addr, Datai} !==
          {exp_hrdata, exp_hreadyout, exp_hresp, exp_rden, exp_wren, exp_addr, exp_datai}) begin
        errors++;
        $display("FAIL random_%0d: got %h/%b/%b/%b/%b/%h/%h want %h/%b/%b/%b/%b/%h/%h",
                 i, HRDATA, HREADYOUT, HRESP, rdEn, wrEn, Addr, Datai, exp_hrdata,
                 exp_hreadyout, exp_hresp, exp_rden, exp_wren, exp_addr, exp_datai);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_idle_busy_desel();
    test_stall();
`ifdef AHBMEM_ERR_EN
    test_errors();
`else
    test_alias();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
